// File: rtl/qdec_pkg.sv
// Shared types, phase constants and Gray-code transition decoder for the quadrature decoder.
package qdec_pkg;

  typedef enum logic {INIT, TRACK} qdec_state_e;

  typedef logic [1:0] qdec_phase_t;

  localparam qdec_phase_t PH_00 = 2'b00;
  localparam qdec_phase_t PH_10 = 2'b10;
  localparam qdec_phase_t PH_11 = 2'b11;
  localparam qdec_phase_t PH_01 = 2'b01;

  // Result is {step, dir, illegal}; the up sequence is 00->10->11->01->00 (A leads B).
  function automatic logic [2:0] qdec_decode(input qdec_phase_t old_ph, input qdec_phase_t new_ph);
    qdec_phase_t next_up;
    logic [2:0]  res;
    case (old_ph)
      PH_00:   next_up = PH_10;
      PH_10:   next_up = PH_11;
      PH_11:   next_up = PH_01;
      default: next_up = PH_00;
    endcase
    res = 3'b000;
    if ((old_ph ^ new_ph) == 2'b11) begin
      res = 3'b001;
    end else if (old_ph != new_ph) begin
      res = {1'b1, (new_ph == next_up), 1'b0};
    end
    return res;
  endfunction

endpackage

// File: rtl/qdec_filter.sv
// Per-phase glitch filter: the output follows the input only after the input has held a new
// level for FILT_CYCLES consecutive cycles.
module qdec_filter #(
  parameter int FILT_CYCLES = 8,
  parameter int FILT_W      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [FILT_W-1:0] cnt;

  // Any return to the accepted level discards the partial count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= 1'b0;
      cnt <= '0;
    end else if (d_i == q_o) begin
      cnt <= '0;
    end else if (cnt == FILT_W'(FILT_CYCLES - 1)) begin
      q_o <= d_i;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronises A/B, optionally filters them (QDEC_GLITCH_FILTER_EN),
// and turns Gray-code transitions into step_en/step_dir pulses plus illegal-transition reporting.
module quad_decoder
  import qdec_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 8,
  parameter int FILT_W      = 4,
  parameter int ERRCNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                phase_a,
  input  logic                phase_b,
  input  logic                en_i,
  input  logic                clr_err,
  output logic                step_en,
  output logic                step_dir,
  output logic                err,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic [1:0]          phase_q
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("quad_decoder: SYNC_STAGES must be at least 2");
  end
  if (FILT_CYCLES < 1 || (2 ** FILT_W) <= FILT_CYCLES) begin : g_bad_filt
    $error("quad_decoder: need FILT_CYCLES >= 1 and 2**FILT_W > FILT_CYCLES");
  end

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic                   acc_a;
  logic                   acc_b;
  qdec_phase_t            new_ph;
  logic [2:0]             dec;
  qdec_state_e            state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], phase_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], phase_b};
    end
  end

`ifdef QDEC_GLITCH_FILTER_EN
  qdec_filter #(.FILT_CYCLES(FILT_CYCLES), .FILT_W(FILT_W)) u_filt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sync_a[SYNC_STAGES-1]),
    .q_o   (acc_a)
  );
  qdec_filter #(.FILT_CYCLES(FILT_CYCLES), .FILT_W(FILT_W)) u_filt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sync_b[SYNC_STAGES-1]),
    .q_o   (acc_b)
  );
`else
  assign acc_a = sync_a[SYNC_STAGES-1];
  assign acc_b = sync_b[SYNC_STAGES-1];
`endif

  assign new_ph = {acc_a, acc_b};
  assign dec    = qdec_decode(qdec_phase_t'(phase_q), new_ph);

  // phase_q tracks the accepted level every cycle in both states, so a re-enable never sees a stale edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      phase_q  <= '0;
      step_en  <= 1'b0;
      step_dir <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      phase_q <= new_ph;
      step_en <= 1'b0;
      err     <= 1'b0;
      case (state)
        INIT: begin
          if (en_i) state <= TRACK;
        end
        TRACK: begin
          if (!en_i) begin
            state <= INIT;
          end else begin
            step_en <= dec[2];
            err     <= dec[0];
            if (dec[2]) step_dir <= dec[1];
          end
        end
        default: state <= INIT;
      endcase
      // A simultaneous clear beats the increment; the err pulse itself is unaffected.
      if (clr_err) begin
        err_cnt <= '0;
      end else if (state == TRACK && en_i && dec[0] && err_cnt != {ERRCNT_W{1'b1}}) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed testbench for quad_decoder; filter-specific cases run when QDEC_GLITCH_FILTER_EN is defined.
module tb_quad_decoder;

  localparam int SYNC_STAGES = 2;
  localparam int FILT_CYCLES = 8;
  localparam int FILT_W      = 4;
  localparam int ERRCNT_W    = 8;
`ifdef QDEC_GLITCH_FILTER_EN
  localparam int LAT = SYNC_STAGES + FILT_CYCLES + 1;
`else
  localparam int LAT = SYNC_STAGES + 1;
`endif
  localparam int HOLD = LAT + 12;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                phase_a;
  logic                phase_b;
  logic                en_i;
  logic                clr_err;
  logic                step_en;
  logic                step_dir;
  logic                err;
  logic [ERRCNT_W-1:0] err_cnt;
  logic [1:0]          phase_q;

  int checks   = 0;
  int failures = 0;
  logic [1:0] cur;
  logic [1:0] nxt;
  int pulses;

  quad_decoder #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CYCLES (FILT_CYCLES),
    .FILT_W      (FILT_W),
    .ERRCNT_W    (ERRCNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .phase_a  (phase_a),
    .phase_b  (phase_b),
    .en_i     (en_i),
    .clr_err  (clr_err),
    .step_en  (step_en),
    .step_dir (step_dir),
    .err      (err),
    .err_cnt  (err_cnt),
    .phase_q  (phase_q)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives {A,B} and checks the pulse appears exactly LAT cycles later and lasts one cycle.
  task automatic applyStimulus(input logic [1:0] ab, input logic exp_step, input logic exp_dir,
                               input logic exp_err, input string tag, input int hold);
    phase_a = ab[1];
    phase_b = ab[0];
    tick(LAT - 1);
    checkOutput({tag, "_early_step"}, step_en, 0);
    checkOutput({tag, "_early_err"}, err, 0);
    tick(1);
    checkOutput({tag, "_step"}, step_en, exp_step);
    checkOutput({tag, "_err"}, err, exp_err);
    if (exp_step) checkOutput({tag, "_dir"}, step_dir, exp_dir);
    tick(1);
    checkOutput({tag, "_step_off"}, step_en, 0);
    checkOutput({tag, "_err_off"}, err, 0);
    checkOutput({tag, "_phase_q"}, phase_q, ab);
    if (exp_step) checkOutput({tag, "_dir_hold"}, step_dir, exp_dir);
    tick(hold - LAT - 1);
  endtask

  initial begin
    rst_n   = 1'b0;
    phase_a = 1'b0;
    phase_b = 1'b0;
    en_i    = 1'b0;
    clr_err = 1'b0;
    #12;
    checkOutput("rst_step_en", step_en, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_err_cnt", err_cnt, 0);
    checkOutput("rst_phase_q", phase_q, 0);
    checkOutput("rst_step_dir", step_dir, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en_i  = 1'b1;
    tick(5);

    // Up sequence
    applyStimulus(2'b10, 1, 1, 0, "up1", HOLD);
    applyStimulus(2'b11, 1, 1, 0, "up2", HOLD);
    applyStimulus(2'b01, 1, 1, 0, "up3", HOLD);
    applyStimulus(2'b00, 1, 1, 0, "up4", HOLD);

    // Down sequence
    applyStimulus(2'b01, 1, 0, 0, "dn1", HOLD);
    applyStimulus(2'b11, 1, 0, 0, "dn2", HOLD);
    applyStimulus(2'b10, 1, 0, 0, "dn3", HOLD);
    applyStimulus(2'b00, 1, 0, 0, "dn4", HOLD);
    checkOutput("dn_err_cnt", err_cnt, 0);

    // Illegal jump and saturation
    applyStimulus(2'b11, 0, 0, 1, "ill1", HOLD);
    checkOutput("ill1_err_cnt", err_cnt, 1);
    cur = 2'b11;
    for (int i = 0; i < 300; i++) begin
      nxt = cur ^ 2'b11;
      applyStimulus(nxt, 0, 0, 1, "sat", LAT + 2);
      cur = nxt;
      if (i == 9) checkOutput("sat_cnt11", err_cnt, 11);
    end
    checkOutput("sat_cnt255", err_cnt, 255);

    // Clear coinciding with an illegal jump
    nxt = cur ^ 2'b11;
    phase_a = nxt[1];
    phase_b = nxt[0];
    tick(LAT - 1);
    clr_err = 1'b1;
    tick(1);
    checkOutput("clr_err_pulse", err, 1);
    checkOutput("clr_step", step_en, 0);
    checkOutput("clr_cnt", err_cnt, 0);
    clr_err = 1'b0;
    tick(1);
    checkOutput("clr_cnt_after", err_cnt, 0);
    checkOutput("clr_err_off", err, 0);
    tick(HOLD);
    cur = nxt;
    checkOutput("clr_phase_q", phase_q, 2'b00);

    // Disable, toggle A three times, re-enable
    en_i   = 1'b0;
    pulses = 0;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      phase_a = ~phase_a;
      for (int j = 0; j < HOLD; j++) begin
        tick(1);
        pulses += int'(step_en) + int'(err);
      end
    end
    en_i = 1'b1;
    for (int j = 0; j < HOLD; j++) begin
      tick(1);
      pulses += int'(step_en) + int'(err);
    end
    checkOutput("dis_no_pulse", pulses, 0);
    checkOutput("dis_phase_q", phase_q, 2'b10);
    applyStimulus(2'b11, 1, 1, 0, "reen", HOLD);
    cur = 2'b11;

`ifdef QDEC_GLITCH_FILTER_EN
    applyStimulus(2'b01, 1, 1, 0, "f_up1", HOLD);
    applyStimulus(2'b00, 1, 1, 0, "f_up2", HOLD);
    pulses  = 0;
    phase_a = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick(1);
      pulses += int'(step_en) + int'(err);
    end
    phase_a = 1'b0;
    for (int j = 0; j < 30; j++) begin
      tick(1);
      pulses += int'(step_en) + int'(err);
    end
    checkOutput("f_glitch", pulses, 0);
    checkOutput("f_glitch_phase_q", phase_q, 2'b00);
    applyStimulus(2'b10, 1, 1, 0, "f_hold", HOLD);
    cur = 2'b10;
`endif

    // Asynchronous reset during a pulse
    nxt = (cur == 2'b10) ? 2'b11 : 2'b01;
    phase_a = nxt[1];
    phase_b = nxt[0];
    tick(LAT);
    checkOutput("arst_pre_step", step_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_step_en", step_en, 0);
    checkOutput("arst_step_dir", step_dir, 0);
    checkOutput("arst_phase_q", phase_q, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
